// File: rtl/pll_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_pkg
// Description : Shared types and helpers for the PLL reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_rst_pkg;

    // Sequencer states; RESET_PLL is the power-on state.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    // Width of a counter that must reach (largest interval - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer_if
// Description : Lock input and reset/status outputs of the PLL reset sequencer.
//               The sequencer uses the master view, its environment the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_reset_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic               pll_locked_in;
    logic               pll_rst_out;
    logic               sys_rst_n_out;
    logic               ready_out;
    logic               fault_out;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  pll_locked_in,
        output pll_rst_out,
        output sys_rst_n_out,
        output ready_out,
        output fault_out,
        output retry_count
    );

    modport slave (
        output pll_locked_in,
        input  pll_rst_out,
        input  sys_rst_n_out,
        input  ready_out,
        input  fault_out,
        input  retry_count
    );

endinterface
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : cdc_sync_bit
// Description : Single-bit multi-flop synchronizer, async active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_data,
    output logic      o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_data};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Pulses the PLL reset, waits for lock with timeout and bounded
//               retries, and releases a stretched system reset only after the
//               lock has been stable. Runs on the free-running reference clock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1000,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES    = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  wire logic              clock_in,
    input  wire logic              rst_n,
    pll_reset_sequencer_if.master  pll_if
);

    localparam int c_CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int c_RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [c_CNT_W-1:0]   c_RST_LAST     = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0]   c_STABLE_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY    = c_RETRY_W'(MAX_RETRIES);

    pll_state_t             r_state;
    pll_state_t             w_next_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_RETRY_W-1:0]   w_retry_next;
    logic                   w_lock_s;

    logic r_pll_rst, r_sys_rst_n, r_ready, r_fault;
    logic w_pll_rst, w_sys_rst_n, w_ready, w_fault;

    // Raw lock comes from the PLL domain; only the synchronized copy is used.
    cdc_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clock_in),
        .rst_n  (rst_n),
        .i_data (pll_if.pll_locked_in),
        .o_sync (w_lock_s)
    );

    // State, shared interval counter (cleared on every state change) and retries.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_PLL;
            r_cnt   <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_next_state;
            r_retry <= w_retry_next;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state != RUN && r_state != FAULT) begin
                // RUN and FAULT have no interval to time, so the counter rests.
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Sequencing decisions; a lock seen on the timeout cycle takes priority.
    always_comb begin
        w_next_state = r_state;
        w_retry_next = r_retry;
        case (r_state)
            RESET_PLL: begin
                if (r_cnt == c_RST_LAST) w_next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next_state = STABILIZE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    if (r_retry < c_MAX_RETRY) begin
                        w_retry_next = r_retry + c_RETRY_W'(1);
                        w_next_state = RESET_PLL;
                    end else begin
                        w_next_state = FAULT;
                    end
                end
            end
            STABILIZE: begin
                // A lock drop here restarts the wait without costing a retry.
                if (!w_lock_s) begin
                    w_next_state = WAIT_LOCK;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (!w_lock_s) w_next_state = RESET_PLL;
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = RESET_PLL;
            end
        endcase
        if (w_next_state == RUN) w_retry_next = '0;
    end

    // Output decode from the next state so outputs move with the state register.
    always_comb begin
        w_pll_rst   = 1'b1;
        w_sys_rst_n = 1'b0;
        w_ready     = 1'b0;
        w_fault     = 1'b0;
        case (w_next_state)
            WAIT_LOCK, STABILIZE: begin
                w_pll_rst = 1'b0;
            end
            RUN: begin
                w_pll_rst   = 1'b0;
                w_sys_rst_n = 1'b1;
                w_ready     = 1'b1;
            end
            FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_pll_rst = 1'b1;
            end
        endcase
    end

    // Registered outputs, glitch-free toward the PLL and system reset trees.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pll_rst   <= w_pll_rst;
            r_sys_rst_n <= w_sys_rst_n;
            r_ready     <= w_ready;
            r_fault     <= w_fault;
        end
    end

    assign pll_if.pll_rst_out   = r_pll_rst;
    assign pll_if.sys_rst_n_out = r_sys_rst_n;
    assign pll_if.ready_out     = r_ready;
    assign pll_if.fault_out     = r_fault;
    assign pll_if.retry_count   = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer: directed timing
//               scenarios plus randomized lock activity against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 20;
    localparam int STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES    = 2;
    localparam int SYNC_STAGES    = 2;

    // Model phase codes (bench-local)
    localparam int P_PLLRST = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STAB   = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_edge   = 0;

    pll_reset_sequencer_if #(.MAX_RETRIES(MAX_RETRIES)) u_if ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_dut (
        .clock_in (clk),
        .rst_n    (rst_n),
        .pll_if   (u_if.master)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_phase;          // which phase of the sequence we are in
    int m_elapsed;        // edges already spent in this phase
    int m_retry;          // retries since last RUN / reset
    bit m_seen [SYNC_STAGES];  // lock samples, [0] newest

    task automatic model_reset();
        m_phase   = P_PLLRST;
        m_elapsed = 0;
        m_retry   = 0;
        for (int i = 0; i < SYNC_STAGES; i++) m_seen[i] = 1'b0;
    endtask

    // Advance one clock edge; lock_in is the raw lock sampled at this edge.
    task automatic model_step(input bit lock_in);
        bit locked;
        int nxt;
        locked = m_seen[SYNC_STAGES-1];
        nxt    = m_phase;
        if (m_phase == P_PLLRST) begin
            if (m_elapsed + 1 >= PLL_RST_CYCLES) nxt = P_WAIT;
        end else if (m_phase == P_WAIT) begin
            if (locked) nxt = P_STAB;
            else if (m_elapsed + 1 >= LOCK_TIMEOUT) begin
                if (m_retry < MAX_RETRIES) begin
                    m_retry = m_retry + 1;
                    nxt = P_PLLRST;
                end else begin
                    nxt = P_FAULT;
                end
            end
        end else if (m_phase == P_STAB) begin
            if (!locked) nxt = P_WAIT;
            else if (m_elapsed + 1 >= STABLE_CYCLES) nxt = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (!locked) nxt = P_PLLRST;
        end
        if (nxt == P_RUN) m_retry = 0;
        m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
        for (int i = SYNC_STAGES - 1; i > 0; i--) m_seen[i] = m_seen[i-1];
        m_seen[0] = lock_in;
    endtask

    // ---------------- checking ----------------
    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, obs, exp, n_edge, $time);
        end
    endtask

    task automatic check_outputs();
        check_value("pll_rst_out",   32'(u_if.pll_rst_out),   32'(m_phase == P_PLLRST || m_phase == P_FAULT));
        check_value("sys_rst_n_out", 32'(u_if.sys_rst_n_out), 32'(m_phase == P_RUN));
        check_value("ready_out",     32'(u_if.ready_out),     32'(m_phase == P_RUN));
        check_value("fault_out",     32'(u_if.fault_out),     32'(m_phase == P_FAULT));
        check_value("retry_count",   32'(u_if.retry_count),   32'(m_retry));
    endtask

    // Drive lock, take one edge, then check at the falling edge.
    task automatic run_cycle(input bit lock);
        u_if.pll_locked_in = lock;
        @(posedge clk);
        model_step(lock);
        n_edge++;
        @(negedge clk);
        check_outputs();
    endtask

    // Assert rst_n mid-cycle, confirm outputs react without a clock edge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("async_pll_rst",   32'(u_if.pll_rst_out),   32'd1);
        check_value("async_sys_rst_n", 32'(u_if.sys_rst_n_out), 32'd0);
        check_value("async_ready",     32'(u_if.ready_out),     32'd0);
        check_value("async_fault",     32'(u_if.fault_out),     32'd0);
        check_value("async_retry",     32'(u_if.retry_count),   32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_edge = 0;
    endtask

    initial begin
        int first_low, first_high, first_sys, first_fault, max_retry, last_retry_low, drop_edge;
        bit cur;
        int remain;

        u_if.pll_locked_in = 1'b0;
        model_reset();

        // 1) lock tied high: 4-edge PLL pulse, system reset released at edge 13
        apply_reset();
        first_low = -1; first_sys = -1; first_high = -1; max_retry = 0;
        for (int i = 0; i < 30; i++) begin
            run_cycle(1'b1);
            if (!u_if.pll_rst_out && first_low < 0) first_low = n_edge;
            if (u_if.sys_rst_n_out && first_sys < 0) first_sys = n_edge;
            if (u_if.ready_out && first_high < 0) first_high = n_edge;
            if (int'(u_if.retry_count) > max_retry) max_retry = int'(u_if.retry_count);
        end
        check_value("pll_pulse_len", first_low, PLL_RST_CYCLES);
        check_value("sys_release_edge", first_sys, PLL_RST_CYCLES + 1 + STABLE_CYCLES);
        check_value("ready_edge", first_high, PLL_RST_CYCLES + 1 + STABLE_CYCLES);
        check_value("no_retry_locked", max_retry, 0);

        // 5) lock falls in RUN: reaction SYNC_STAGES+1 edges later, then a fresh pulse
        drop_edge = n_edge + 1;
        first_sys = -1; first_high = -1; first_low = -1;
        for (int i = 0; i < 15; i++) begin
            run_cycle(i < 5 ? 1'b0 : 1'b1);
            if (!u_if.sys_rst_n_out && first_sys < 0) first_sys = n_edge;
            if (u_if.pll_rst_out && first_high < 0) first_high = n_edge;
            if (first_high >= 0 && !u_if.pll_rst_out && first_low < 0) first_low = n_edge;
        end
        check_value("runloss_sys_latency", first_sys - drop_edge + 1, SYNC_STAGES + 1);
        check_value("runloss_pll_latency", first_high - drop_edge + 1, SYNC_STAGES + 1);
        check_value("runloss_pulse_len", first_low - first_high, PLL_RST_CYCLES);

        // 2) lock never arrives: three pulses, retries 0->1->2, then sticky fault
        apply_reset();
        first_fault = -1; max_retry = 0;
        for (int i = 0; i < 100; i++) begin
            run_cycle(1'b0);
            if (u_if.fault_out && first_fault < 0) first_fault = n_edge;
            if (int'(u_if.retry_count) > max_retry) max_retry = int'(u_if.retry_count);
        end
        check_value("fault_edge", first_fault, (MAX_RETRIES + 1) * (PLL_RST_CYCLES + LOCK_TIMEOUT));
        check_value("fault_max_retry", max_retry, MAX_RETRIES);
        check_value("fault_pll_rst_held", 32'(u_if.pll_rst_out), 32'd1);
        // 6b) rst_n in FAULT
        apply_reset();
        for (int i = 0; i < 6; i++) run_cycle(1'b0);

        // 3) lock appears during the second wait window
        apply_reset();
        last_retry_low = -1;
        for (int i = 0; i < 80; i++) begin
            run_cycle(i < 33 ? 1'b0 : 1'b1);
            if (!u_if.sys_rst_n_out) last_retry_low = int'(u_if.retry_count);
        end
        check_value("late_lock_retry_before_run", last_retry_low, 1);
        check_value("late_lock_retry_in_run", 32'(u_if.retry_count), 32'd0);
        check_value("late_lock_running", 32'(u_if.ready_out), 32'd1);

        // 4) lock drops for 3 edges after 5 STABILIZE edges
        apply_reset();
        first_sys = -1; max_retry = 0;
        for (int i = 1; i <= 40; i++) begin
            run_cycle((i >= 9 && i <= 11) ? 1'b0 : 1'b1);
            if (u_if.sys_rst_n_out && first_sys < 0) first_sys = n_edge;
            if (int'(u_if.retry_count) > max_retry) max_retry = int'(u_if.retry_count);
        end
        // lock seen high again from edge 12; synchronizer + full stable interval
        check_value("stab_drop_run_edge", first_sys, 12 + SYNC_STAGES + STABLE_CYCLES);
        check_value("stab_drop_no_retry", max_retry, 0);

        // 6a) rst_n in STABILIZE, then a clean restart
        apply_reset();
        for (int i = 0; i < 8; i++) run_cycle(1'b1);
        apply_reset();
        first_sys = -1;
        for (int i = 0; i < 16; i++) begin
            run_cycle(1'b1);
            if (u_if.sys_rst_n_out && first_sys < 0) first_sys = n_edge;
        end
        check_value("restart_release_edge", first_sys, PLL_RST_CYCLES + 1 + STABLE_CYCLES);

        // 7) randomized lock activity with occasional resets
        apply_reset();
        cur = 1'b0; remain = 0;
        for (int i = 0; i < 1500; i++) begin
            if (remain == 0) begin
                cur    = ~cur;
                remain = cur ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 45));
            end
            run_cycle(cur);
            remain--;
            if ($urandom_range(0, 199) == 0) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Drives the reset input of the GateMate PLL wrapper and turns its raw lock indication into a clean, stretched system reset. It runs on the free-running reference clock, so it stays alive while the PLL output is absent. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires a lock-stable interval before releasing reset. On loss of lock it re-asserts system reset and re-sequences the PLL.

## Interface
- `PLL_RST_CYCLES`, default 16: cycles the PLL reset is held high per attempt (≥1).
- `LOCK_TIMEOUT`, default 1000: cycles to wait for lock after PLL reset release (100 µs at 10 MHz).
- `STABLE_CYCLES`, default 256: consecutive synchronized-lock-high cycles required before releasing system reset (≥1).
- `MAX_RETRIES`, default 3: PLL re-reset attempts after the first timeout before declaring fault.
- `SYNC_STAGES`, default 2: synchronizer depth for the lock input (≥2).
- `clock_in`, in, 1: reference clock, free-running, not PLL-derived.
- `rst_n`, in, 1: asynchronous active-low reset; asserts all registers immediately.
- `pll_locked_in`, in, 1: raw PLL lock, asynchronous to `clock_in`.
- `pll_rst_out`, out, 1: active-high reset to PLL wrapper `rst_in`.
- `sys_rst_n_out`, out, 1: active-low system reset; consumers in the PLL clock domain re-time deassertion.
- `ready_out`, out, 1: high only in RUN.
- `fault_out`, out, 1: sticky; retries exhausted.
- `retry_count`, out, RETRY_W = $clog2(MAX_RETRIES+1): retries performed since last RUN or `rst_n`.

## Operation
- Lock passes through a SYNC_STAGES flop chain. `lock_s` is the last stage; FSM logic uses only `lock_s`.
- One shared cycle counter `cnt`, width to hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It clears on every state change.
- RESET_PLL (reset state): `pll_rst_out`=1, `sys_rst_n_out`=0. When `cnt`==PLL_RST_CYCLES-1 → WAIT_LOCK.
- WAIT_LOCK: `pll_rst_out`=0.
  - `lock_s`=1 → STABILIZE.
  - Else if `cnt`==LOCK_TIMEOUT-1:
    - `retry_count`<MAX_RETRIES → increment `retry_count`, go to RESET_PLL.
    - Else → FAULT.
  - If lock arrives on the timeout cycle, lock wins.
- STABILIZE:
  - `lock_s`=0 → WAIT_LOCK. `cnt` restarts and no retry is counted.
  - `cnt`==STABLE_CYCLES-1 with `lock_s`=1 → RUN.
- RUN: `sys_rst_n_out`=1, `ready_out`=1, `retry_count` cleared to 0. `lock_s`=0 → RESET_PLL.
- FAULT: `pll_rst_out`=1, `sys_rst_n_out`=0, `fault_out`=1. Only `rst_n` exits FAULT.
- Reset values: state RESET_PLL, `cnt`=0, sync chain 0, `pll_rst_out`=1, `sys_rst_n_out`=0, `ready_out`=0, `fault_out`=0, `retry_count`=0.
- Mid-operation `rst_n` assertion from any state returns all outputs to their reset values asynchronously.

## Timing
- All outputs are registered and decoded from the next state, so each output changes in the same cycle as the state.
- After `rst_n` deasserts, `pll_rst_out` stays high for exactly PLL_RST_CYCLES rising edges.
- Lock-input latency: SYNC_STAGES cycles from a `pll_locked_in` edge to a `lock_s` edge.
- Best case, lock already high: `sys_rst_n_out` rises PLL_RST_CYCLES + 1 + STABLE_CYCLES cycles after the first edge following reset release.
  - The +1 is the WAIT_LOCK detection cycle.
  - Synchronizer fill overlaps RESET_PLL when PLL_RST_CYCLES ≥ SYNC_STAGES.
- Lock loss in RUN: `sys_rst_n_out` falls SYNC_STAGES+1 cycles after the `pll_locked_in` fall, and `pll_rst_out` rises on the same edge.
- Glitches on `pll_locked_in` shorter than one cycle may be missed; by design, only STABILIZE/RUN reaction is defined.

## Structure
- Package `pll_rst_pkg`:
  - state enum: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT;
  - a `cnt_width` function computing $clog2 of the max parameter.
- Sub-module `cdc_sync_bit`: parameterized SYNC_STAGES flop chain with async active-low reset to 0. It is reused by other cross-domain single bits.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- Lock tied high → `pll_rst_out` high for exactly 4 cycles; `sys_rst_n_out` and `ready_out` rise 13 cycles after reset release; `retry_count`=0.
- Lock never asserts → three PLL reset pulses of 4 cycles, 20 cycles apart; `retry_count` goes 0→1→2; then `fault_out`=1 and `pll_rst_out`=1 permanently until `rst_n`.
- Lock arrives during second wait → `retry_count`=1 during STABILIZE; returns to 0 on RUN entry.
- Lock drops for 3 cycles after 5 STABILIZE cycles → return to WAIT_LOCK with no retry counted; RUN entered 8 full stable cycles after lock returns.
- Lock falls in RUN → `sys_rst_n_out`=0 and `pll_rst_out`=1 exactly 3 cycles later; a 4-cycle PLL reset pulse follows.
- `rst_n` pulsed low in STABILIZE and in FAULT → all outputs return to reset values immediately; the sequence restarts from RESET_PLL.
